// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock.
// The round key schedule is walked backwards from the round-10 key by an
// external key-step unit. The inverse-round datapath is also external.
// This block holds the state/key registers, round counter, FSM and handshakes.
module aes_dec_round_ctrl #(
   parameter int NR = 10,
   parameter int W  = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] ct_in,
   input  logic [W-1:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] pt_out,
   output logic         busy,
   output logic [W-1:0] rnd_state_o,
   output logic [W-1:0] rnd_key_o,
   output logic         rnd_last_o,
   input  logic [W-1:0] rnd_state_i,
   output logic [W-1:0] ksch_key_o,
   output logic [7:0]   ksch_rcon_o,
   input  logic [W-1:0] ksch_key_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t         fsm_reg, fsm_next;
   logic [3:0]   rnd_reg, rnd_next;
   logic [W-1:0] state_reg, state_next;
   logic [W-1:0] key_reg, key_next;
   logic [7:0]   rcon;

   // Rcon of the forward step that produced the current round key; the
   // inverse key step needs the same constant to undo it.
   always_comb begin
      rcon = 8'h00;
      case (rnd_reg)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // Next-state logic: load on accept, step one round per RUN cycle,
   // hold the result in DONE until the consumer takes it.
   always_comb begin
      fsm_next   = fsm_reg;
      rnd_next   = rnd_reg;
      state_next = state_reg;
      key_next   = key_reg;
      case (fsm_reg)
         IDLE: begin
            if (in_valid) begin
               // Initial AddRoundKey with the last round key happens here.
               state_next = ct_in ^ key_in;
               key_next   = key_in;
               rnd_next   = 4'(NR);
               fsm_next   = RUN;
            end
         end
         RUN: begin
            state_next = rnd_state_i;
            key_next   = ksch_key_i;
            if (rnd_reg != 4'd0) begin
               rnd_next = rnd_reg - 4'd1;
            end
            if (rnd_reg <= 4'd1) begin
               fsm_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_next = IDLE;
            end
         end
         default: fsm_next = IDLE;
      endcase
   end

   // Register update; reset aborts any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_reg   <= IDLE;
         rnd_reg   <= 4'd0;
         state_reg <= '0;
         key_reg   <= '0;
      end else begin
         fsm_reg   <= fsm_next;
         rnd_reg   <= rnd_next;
         state_reg <= state_next;
         key_reg   <= key_next;
      end
   end

   // No new job while one is running or waiting to be collected.
   assign in_ready    = (fsm_reg == IDLE) && !rst;
   assign out_valid   = (fsm_reg == DONE);
   assign pt_out      = (fsm_reg == DONE) ? state_reg : '0;
   assign busy        = (fsm_reg == RUN) || (fsm_reg == DONE);

   assign rnd_state_o = state_reg;
   assign ksch_key_o  = key_reg;
   assign rnd_key_o   = ksch_key_i;
   assign ksch_rcon_o = (fsm_reg == RUN) ? rcon : 8'h00;
   assign rnd_last_o  = (fsm_reg == RUN) && (rnd_reg == 4'd1);

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: supplies behavioural inverse-round and
// inverse key-step units, and checks results against forward AES encryption.
module tb_aes_dec_round_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ct_in;
   logic [127:0] key_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt_out;
   logic         busy;
   logic [127:0] rnd_state_o;
   logic [127:0] rnd_key_o;
   logic         rnd_last_o;
   logic [127:0] rnd_state_i;
   logic [127:0] ksch_key_o;
   logic [7:0]   ksch_rcon_o;
   logic [127:0] ksch_key_i;

   logic [7:0] sbox [256];
   logic [7:0] inv_sbox [256];
   logic [7:0] rcon_tbl [11];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_dec_round_ctrl #(.NR(10), .W(128)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ct_in(ct_in), .key_in(key_in), .out_valid(out_valid),
      .out_ready(out_ready), .pt_out(pt_out), .busy(busy),
      .rnd_state_o(rnd_state_o), .rnd_key_o(rnd_key_o),
      .rnd_last_o(rnd_last_o), .rnd_state_i(rnd_state_i),
      .ksch_key_o(ksch_key_o), .ksch_rcon_o(ksch_rcon_o),
      .ksch_key_i(ksch_key_i)
   );

   // ---------------- GF(2^8) and AES primitives ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
      logic [127:0] r;
      logic [7:0] b;
      for (int i = 0; i < 16; i++) begin
         b = s[127-8*i -: 8];
         r[127-8*i -: 8] = inv ? inv_sbox[b] : sbox[b];
      end
      return r;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
      logic [127:0] r;
      int src, dst;
      for (int row = 0; row < 4; row++) begin
         for (int c = 0; c < 4; c++) begin
            src = row + 4 * ((c + row) % 4);
            dst = row + 4 * c;
            if (inv) r[127-8*src -: 8] = s[127-8*dst -: 8];
            else     r[127-8*dst -: 8] = s[127-8*src -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
      logic [127:0] r;
      logic [7:0] m [4];
      logic [7:0] acc;
      if (inv) begin
         m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      end else begin
         m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(m[(j - row + 4) % 4], s[127-8*(4*c+j) -: 8]);
            r[127-8*(4*c+row) -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      logic [31:0] t = {w[23:0], w[31:24]};
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0]  ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [127:0] t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
      return last ? t : mix_cols(t, 1'b1);
   endfunction

   // Forward AES-128: reference producing ciphertext and the round-10 key.
   task automatic encrypt(input logic [127:0] pt, input logic [127:0] key,
                          output logic [127:0] ct, output logic [127:0] k10);
      logic [127:0] k = key;
      logic [127:0] s = pt ^ key;
      for (int r = 1; r <= 10; r++) begin
         k = key_fwd(k, rcon_tbl[r]);
         s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
         if (r < 10) s = mix_cols(s, 1'b0);
         s = s ^ k;
      end
      ct = s;
      k10 = k;
   endtask

   // External datapath models driven by the DUT.
   always_comb rnd_state_i = inv_round(rnd_state_o, rnd_key_o, rnd_last_o);
   always_comb ksch_key_i  = key_inv(ksch_key_o, ksch_rcon_o);

   // ---------------- stimulus helpers (no checks) ----------------
   task automatic send(input logic [127:0] ct, input logic [127:0] key);
      @(negedge clk);
      ct_in = ct; key_in = key; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      ct_in = 128'h1; key_in = 128'h2;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (pt_out !== 128'h0) begin errors++; $display("FAIL rst_pt_out got %h exp 0", pt_out); end
      checks++; if (rnd_state_o !== 128'h0 || ksch_key_o !== 128'h0) begin errors++; $display("FAIL rst_regs got %h/%h exp 0", rnd_state_o, ksch_key_o); end
      checks++; if (ksch_rcon_o !== 8'h00 || rnd_last_o !== 1'b0) begin errors++; $display("FAIL rst_rcon_last got %h/%b exp 00/0", ksch_rcon_o, rnd_last_o); end
      in_valid = 1'b0; rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_accept_busy got %b exp 0", busy); end
      $display("reset done");
   endtask

   task automatic test_fips_c1();
      logic [127:0] ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      logic [127:0] key = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      send(ct, key);
      for (int k = 1; k <= 10; k++) begin
         checks++; if (ksch_rcon_o !== rcon_tbl[11-k]) begin errors++; $display("FAIL c1_rcon_r%0d got %h exp %h", k, ksch_rcon_o, rcon_tbl[11-k]); end
         checks++; if (rnd_last_o !== (k == 10)) begin errors++; $display("FAIL c1_last_r%0d got %b exp %b", k, rnd_last_o, k == 10); end
         checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL c1_run_flags_r%0d got v%b b%b r%b exp v0 b1 r0", k, out_valid, busy, in_ready); end
         if (k == 1) begin
            checks++; if (rnd_key_o !== 128'h549932d1f08557681093ed9cbe2c974e) begin errors++; $display("FAIL c1_key_first got %h exp 549932d1f08557681093ed9cbe2c974e", rnd_key_o); end
         end
         if (k == 10) begin
            checks++; if (rnd_key_o !== 128'h000102030405060708090a0b0c0d0e0f) begin errors++; $display("FAIL c1_key_last got %h exp 000102030405060708090a0b0c0d0e0f", rnd_key_o); end
         end
         @(negedge clk);
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL c1_latency out_valid got %b exp 1", out_valid); end
      checks++; if (pt_out !== 128'h00112233445566778899aabbccddeeff) begin errors++; $display("FAIL c1_pt got %h exp 00112233445566778899aabbccddeeff", pt_out); end
      checks++; if (ksch_rcon_o !== 8'h00 || rnd_last_o !== 1'b0) begin errors++; $display("FAIL c1_done_rcon got %h/%b exp 00/0", ksch_rcon_o, rnd_last_o); end
      $display("job c1 ct=%h pt=%h", ct, pt_out);
      release_out();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL c1_handoff got v%b r%b exp v0 r1", out_valid, in_ready); end
   endtask

   task automatic test_fips_b();
      int n;
      send(128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      wait_valid(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL b_latency got %0d exp 10", n); end
      checks++; if (pt_out !== 128'h3243f6a8885a308d313198a2e0370734) begin errors++; $display("FAIL b_pt got %h exp 3243f6a8885a308d313198a2e0370734", pt_out); end
      $display("job appB pt=%h", pt_out);
      release_out();
   endtask

   task automatic test_random();
      logic [127:0] pt, key, ct, k10;
      int n;
      for (int j = 0; j < 6; j++) begin
         pt = rand128(); key = rand128();
         encrypt(pt, key, ct, k10);
         send(ct, k10);
         // out_ready raised early must not disturb the run.
         if (j % 2 == 1) out_ready = 1'b1;
         wait_valid(n);
         checks++; if (n !== 10) begin errors++; $display("FAIL rand%0d_latency got %0d exp 10", j, n); end
         checks++; if (pt_out !== pt) begin errors++; $display("FAIL rand%0d_pt got %h exp %h", j, pt_out, pt); end
         $display("job rand%0d ct=%h pt=%h", j, ct, pt_out);
         release_out();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] pt, key, ct, k10;
      int n;
      pt = rand128(); key = rand128();
      encrypt(pt, key, ct, k10);
      send(ct, k10);
      wait_valid(n);
      checks++; if (pt_out !== pt) begin errors++; $display("FAIL bp_pt got %h exp %h", pt_out, pt); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || pt_out !== pt || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v%b r%b pt %h exp v1 r0 pt %h", i, out_valid, in_ready, pt_out, pt); end
      end
      release_out();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_handoff got r%b v%b exp r1 v0", in_ready, out_valid); end
      $display("job bp1 pt=%h", pt);
      pt = rand128(); key = rand128();
      encrypt(pt, key, ct, k10);
      send(ct, k10);
      wait_valid(n);
      checks++; if (n !== 10 || pt_out !== pt) begin errors++; $display("FAIL bp_second got %h lat %0d exp %h lat 10", pt_out, n, pt); end
      $display("job bp2 pt=%h", pt_out);
      release_out();
   endtask

   task automatic test_busy_input();
      logic [127:0] pt, key, ct, k10;
      int n;
      pt = rand128(); key = rand128();
      encrypt(pt, key, ct, k10);
      send(ct, k10);
      repeat (2) @(negedge clk);
      ct_in = ~ct; key_in = rand128(); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL busy_latency got %0d exp 7", n); end
      checks++; if (pt_out !== pt) begin errors++; $display("FAIL busy_pt got %h exp %h", pt_out, pt); end
      $display("job busy pt=%h", pt_out);
      release_out();
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL busy_no_ghost got b%b v%b exp b0 v0", busy, out_valid); end
   endtask

   task automatic test_reset_mid_run();
      logic [127:0] pt, key, ct, k10;
      bit spurious = 1'b0;
      int n;
      pt = rand128(); key = rand128();
      encrypt(pt, key, ct, k10);
      send(ct, k10);
      repeat (5) @(negedge clk);
      checks++; if (ksch_rcon_o !== rcon_tbl[5]) begin errors++; $display("FAIL mid_rnd5 rcon got %h exp %h", ksch_rcon_o, rcon_tbl[5]); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || pt_out !== 128'h0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset got v%b b%b r%b pt %h exp v0 b0 r0 pt 0", out_valid, busy, in_ready, pt_out); end
      checks++; if (rnd_state_o !== 128'h0 || ksch_rcon_o !== 8'h00) begin errors++; $display("FAIL mid_reset_regs got %h/%h exp 0/00", rnd_state_o, ksch_rcon_o); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
      end
      checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL mid_spurious got 1 exp 0"); end
      pt = rand128(); key = rand128();
      encrypt(pt, key, ct, k10);
      send(ct, k10);
      wait_valid(n);
      checks++; if (n !== 10 || pt_out !== pt) begin errors++; $display("FAIL mid_after got %h lat %0d exp %h lat 10", pt_out, n, pt); end
      $display("job after_reset pt=%h", pt_out);
      release_out();
   endtask

   initial begin
      // Build S-boxes from multiplicative inverse plus affine map.
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv, base, s;
         inv = 8'h01; base = 8'(x);
         for (int e = 0; e < 8; e++) begin
            if (e != 0) inv = gmul(inv, base);
            base = gmul(base, base);
         end
         if (x == 0) inv = 8'h00;
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x] = s;
         inv_sbox[s] = 8'(x);
      end
      rcon_tbl[0] = 8'h00;
      rcon_tbl[1] = 8'h01;
      for (int i = 2; i <= 10; i++) rcon_tbl[i] = xtime(rcon_tbl[i-1]);

      test_reset();
      test_fips_c1();
      test_fips_b();
      test_random();
      test_backpressure();
      test_busy_input();
      test_reset_mid_run();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
